// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency imem and
// hands (instr, pc) to decode through a response slot plus a 1-entry hold buffer.
module if_fetch #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]           imem_data_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [31:0]           instr_pc_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    // Redirect targets are word aligned; the low two bits are dropped.
    logic [1:0] unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // Handshake: an instruction transfers on a posedge where instr_valid_o=1,
    // stall_i=0 and redirect_i=0; while stalled the same (instr, pc) is held.
    assign instr_valid_o = hold_valid_q | resp_valid_q;
    assign instr_o       = hold_valid_q ? hold_instr_q :
                           (resp_valid_q ? imem_data_i : NOP);
    assign instr_pc_o    = hold_valid_q ? hold_pc_q : resp_pc_q;

    // While the hold buffer is full, re-read resp_pc so imem_data_i stays put.
    assign imem_addr_o = hold_valid_q ? resp_pc_q[ADDR_WIDTH+1:2]
                                      : fetch_pc_q[ADDR_WIDTH+1:2];

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (redirect_i) begin
            fetch_pc_d   = {redirect_pc_i[31:2], 2'b00};
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (!hold_valid_q) begin
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            // Park the stalled response so the new request's data can land.
            if (stall_i && resp_valid_q) begin
                hold_valid_d = 1'b1;
                hold_instr_d = imem_data_i;
                hold_pc_d    = resp_pc_q;
            end
        end else if (!stall_i) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule
